dm_responder: RTL and testbench
===============================

# dm_responder

Data-memory responder for the MIPS core: the memory-side end of the core's load/store port, serving one word-wide request at a time over a valid/ready handshake. It holds the data array, inserts a configurable number of wait states, applies byte-enable writes, flags bad addresses and emits a one-cycle write-trace event for the verification log. It sits beside the core's top level, replacing the zero-wait combinational data memory once the core stalls on memory.

## Interface
- ADDR_WIDTH, 12, word-address width; capacity is 2^ADDR_WIDTH words.
- LATENCY, 2, number of wait cycles, range 0..15.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low (0 = reset).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables; bit i covers byte lane i, bits [8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  requester takes the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  address error on this response.
- wr_evt  output  1  one-cycle pulse when a store updates memory.
- wr_addr  output  32  word-aligned byte address of that store.
- wr_data  output  32  full word after the byte merge.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE
  - req_ready=1.
  - On req_valid: latch we, addr, wdata and be; load cnt=LATENCY; go to WAIT.
- WAIT
  - req_ready=0.
  - If cnt!=0: cnt decrements by 1.
  - If cnt==0: perform the access this cycle, register the response, go to RESP.
- RESP
  - resp_valid=1; resp_rdata and resp_err hold stable.
  - On resp_ready=1: return to IDLE. A new request is not accepted in this same cycle.
- Address error: addr[1:0]!=0, or addr[31:ADDR_WIDTH+2]!=0.
  - On error: resp_err=1, resp_rdata=0, memory untouched, no wr_evt.
- Load:
  - resp_rdata = mem[addr[ADDR_WIDTH+1:2]], the full word.
  - req_be is ignored.
- Store:
  - Byte lane i is replaced when be[i]=1; all other lanes are kept.
  - resp_rdata=0.
  - be=0 is a legal no-op: no error and no wr_evt.
- wr_evt: high for the single access cycle of each valid store with be!=0.
  - wr_addr = {addr[31:2],2'b00}.
  - wr_data = merged word, equal to the memory contents after the edge.
- Only one request is outstanding at a time; inputs are sampled only in IDLE.

## Timing
- Reset (reset=0 at a clock edge):
  - State goes to IDLE; cnt=0.
  - All memory words become 0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wr_evt=0, wr_addr=0, wr_data=0.
- Reset mid-operation (WAIT or RESP): the transaction is dropped with no response. A store whose access cycle coincides with reset does not take effect; the reset clear wins.
- Request accepted at edge k. The memory write, if any, lands at edge k+LATENCY+1. resp_valid is first high in the cycle after edge k+LATENCY+1.
- Minimum request-to-request spacing is LATENCY+3 cycles, with resp_ready tied high.
- resp_ready held low keeps the responder in RESP indefinitely; outputs stay stable and req_ready stays 0.
- resp_ready is ignored outside RESP.
- wr_evt is asserted in the cycle before resp_valid rises and is 0 in every other cycle.

## Test plan
- Reset: hold reset=0 for 2 cycles, release → req_ready=1, resp_valid=0, wr_evt=0; a load of 0x0000_0010 returns 0x0000_0000.
- Store/load with LATENCY=2:
  - Store 0x1234_5678 to 0x0000_0040 with be=4'hF, accepted at edge k → wr_evt at cycle k+2, wr_addr=0x40, resp_valid in cycle k+3, resp_err=0.
  - A following load of 0x40 → resp_rdata=0x1234_5678.
- Byte merge: word 0x40 holds 0x1234_5678; store 0xAABB_CCDD with be=4'b0101 → wr_data=0x12BB_56DD; a load returns 0x12BB_56DD.
- Errors:
  - Load of 0x0000_0042 → resp_err=1, resp_rdata=0.
  - Store to 0x0000_4000 (ADDR_WIDTH=12) → resp_err=1, no wr_evt, no memory change.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid, resp_rdata and resp_err stable, req_ready=0; raise resp_ready → IDLE the next cycle.
- Reset in WAIT: store 0xDEAD_BEEF to 0x80, drive reset=0 one cycle after acceptance → no resp_valid, no wr_evt; a later load of 0x80 returns 0.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder: word-wide load/store port with byte-enable merge and address checks.
// Latency: access LATENCY+1 edges after acceptance; response registered the cycle after.
// Backpressure: one request outstanding; holds response in RESP until resp_ready.
module dm_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        wr_evt,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    lat_we;
    logic [31:0]             lat_addr;
    logic [31:0]             lat_wdata;
    logic [3:0]              lat_be;

    // Per-word written flags give a single-cycle clear of the whole array on reset.
    logic [31:0]             mem [DEPTH];
    logic [DEPTH-1:0]        word_vld;

    logic                    sel_we;
    logic [31:0]             sel_addr;
    logic [31:0]             sel_wdata;
    logic [3:0]              sel_be;
    logic [ADDR_WIDTH-1:0]   sel_idx;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic                    sel_store;
    logic                    prep;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
        end
        return m;
    endfunction

    function automatic logic [31:0] rd_word(input logic [ADDR_WIDTH-1:0] idx);
        return word_vld[idx] ? mem[idx] : 32'd0;
    endfunction

    // The merged store word is prepared one edge ahead so wr_evt/wr_data are
    // registered and valid during the access cycle itself.
    always_comb begin
        sel_we    = (state == IDLE) ? req_we    : lat_we;
        sel_addr  = (state == IDLE) ? req_addr  : lat_addr;
        sel_wdata = (state == IDLE) ? req_wdata : lat_wdata;
        sel_be    = (state == IDLE) ? req_be    : lat_be;
        sel_idx   = sel_addr[ADDR_WIDTH+1:2];
        lat_idx   = lat_addr[ADDR_WIDTH+1:2];
        sel_store = sel_we && (sel_be != 4'd0) && !addr_bad(sel_addr);
        prep      = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                    ((state == WAIT) && (cnt == 4'd1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_be     <= 4'd0;
            word_vld   <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            wr_evt     <= 1'b0;
            wr_addr    <= 32'd0;
            wr_data    <= 32'd0;
        end else begin
            if (prep) begin
                wr_evt <= sel_store;
                if (sel_store) begin
                    wr_addr <= {sel_addr[31:2], 2'b00};
                    wr_data <= merge(rd_word(sel_idx), sel_wdata, sel_be);
                end
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        cnt       <= 4'(LATENCY);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (wr_evt) begin
                            mem[lat_idx]      <= wr_data;
                            word_vld[lat_idx] <= 1'b1;
                        end
                        wr_evt     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= addr_bad(lat_addr);
                        resp_rdata <= (addr_bad(lat_addr) || lat_we) ? 32'd0 : rd_word(lat_idx);
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: expected responses and write events queued at issue time.
module tb_dm_responder;
    localparam int AW  = 12;
    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        wr_evt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    dm_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .wr_evt(wr_evt), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [31:0] rdata; logic err; int cyc;} resp_t;
    typedef struct {logic [31:0] addr; logic [31:0] data; int cyc;} wr_t;

    resp_t       rq[$];
    wr_t         wq[$];
    logic [31:0] mdl [int];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          resp_cnt = 0;
    int          exp_resp = 0;
    bit          rv_prev  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: every write event and response handshake must match the queue head.
    always @(negedge clk) begin : mon
        wr_t   w;
        resp_t r;
        if (wr_evt) begin
            if (wq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else begin
                w = wq.pop_front();
                chk("wr_addr", wr_addr, w.addr);
                chk("wr_data", wr_data, w.data);
                chk("wr_cycle", 32'(cyc), 32'(w.cyc));
            end
        end
        if (resp_valid && !rv_prev) begin
            if (rq.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
            else chk("resp_cycle", 32'(cyc), 32'(rq[0].cyc));
        end
        if (resp_valid && resp_ready && rq.size() != 0) begin
            r = rq.pop_front();
            chk("resp_rdata", resp_rdata, r.rdata);
            chk("resp_err", 32'(resp_err), 32'(r.err));
            resp_cnt++;
        end
        rv_prev = resp_valid;
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input bit track);
        int          k;
        int          g;
        int          idx;
        bit          err;
        logic [31:0] old;
        logic [31:0] mrg;
        resp_t       r;
        wr_t         w;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        @(posedge clk);
        #1;
        k = cyc;
        req_valid = 1'b0;
        if (track) begin
            err = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
            idx = int'(addr[AW+1:2]);
            old = mdl.exists(idx) ? mdl[idx] : 32'd0;
            r.err   = err;
            r.cyc   = k + LAT + 1;
            r.rdata = (err || we) ? 32'd0 : old;
            if (we && !err && be != 4'd0) begin
                for (int i = 0; i < 4; i++) mrg[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
                mdl[idx] = mrg;
                w.addr = {addr[31:2], 2'b00};
                w.data = mrg;
                w.cyc  = k + LAT;
                wq.push_back(w);
            end
            rq.push_back(r);
            exp_resp++;
        end
    endtask

    task automatic wait_resp();
        int g;
        g = 0;
        while (resp_cnt < exp_resp && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("resp_timeout", 32'(resp_cnt >= exp_resp), 32'd1);
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be);
        issue(we, addr, wd, be, 1'b1);
        wait_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_be     = 4'd0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mdl.delete();
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_wr_evt", 32'(wr_evt), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);

        txn(1'b0, 32'h0000_0010, 32'd0, 4'hF);
        txn(1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF);
        txn(1'b0, 32'h0000_0040, 32'd0, 4'h0);
        txn(1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0101);
        txn(1'b0, 32'h0000_0040, 32'd0, 4'hF);
        txn(1'b0, 32'h0000_0042, 32'd0, 4'hF);
        txn(1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF);
        txn(1'b0, 32'h0000_0000, 32'd0, 4'hF);
        txn(1'b1, 32'h0000_0040, 32'h5555_5555, 4'h0);
        txn(1'b0, 32'h0000_0040, 32'd0, 4'h3);
        txn(1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 4'b1010);
        txn(1'b0, 32'h0000_3FFC, 32'd0, 4'hF);
        txn(1'b1, 32'h0000_3FFC, 32'h0102_0304, 4'b0001);
        txn(1'b0, 32'h0000_3FFC, 32'd0, 4'hF);
        txn(1'b0, 32'h4000_0000, 32'd0, 4'hF);
        txn(1'b1, 32'h0000_0081, 32'h1111_1111, 4'hF);

        // Backpressure: response must hold while resp_ready is low.
        resp_ready = 1'b0;
        issue(1'b0, 32'h0000_0040, 32'd0, 4'hF, 1'b1);
        g = 0;
        while (!resp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("bp_arrive", 32'(resp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, 32'h12BB_56DD);
            chk("bp_err", 32'(resp_err), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_req_ready", 32'(req_ready), 32'd1);
        chk("bp_idle_resp_valid", 32'(resp_valid), 32'd0);
        wait_resp();

        // Reset while the store is in WAIT: no response, no write, memory cleared.
        issue(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 4'hF, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        mdl.delete();
        repeat (6) @(negedge clk);
        chk("rstwait_resp_valid", 32'(resp_valid), 32'd0);
        chk("rstwait_req_ready", 32'(req_ready), 32'd1);
        txn(1'b0, 32'h0000_0080, 32'd0, 4'hF);
        txn(1'b0, 32'h0000_0040, 32'd0, 4'hF);

        repeat (3) @(negedge clk);
        chk("wr_queue_drained", 32'(wq.size()), 32'd0);
        chk("resp_queue_drained", 32'(rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
